// File: rtl/move_packet_rx.sv
// Framed move-packet decoder: A5, count, x/y pairs, optional XOR checksum.
// Optional feature macro: MOVE_CSUM_EN (adds the trailing checksum byte and its check).
module move_packet_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [5:0] x_1,
    output logic [5:0] y_1,
    output logic [5:0] x_2,
    output logic [5:0] y_2,
    output logic [1:0] move_count,
    output logic       move_valid,
    input  logic       move_ack,
    output logic       pkt_error,
    output logic [7:0] err_count
);

    localparam logic [7:0] HDR = 8'hA5;

`ifdef MOVE_CSUM_EN
    typedef enum logic [2:0] {IDLE, COUNT, X1, Y1, X2, Y2, CSUM, HOLD} state_t;
`else
    typedef enum logic [2:0] {IDLE, COUNT, X1, Y1, X2, Y2, HOLD} state_t;
`endif

    state_t     state;
    logic [1:0] cnt_r;
    logic [5:0] x1_r, y1_r, x2_r, y2_r;
`ifdef MOVE_CSUM_EN
    logic [7:0] csum_r;
`endif

    logic       accept;
    logic       is_coord;
    logic       bad;
    logic       commit;
    logic [5:0] c_y1, c_y2;

    // Coordinates are staged in shadow registers and only copied to the
    // outputs on a complete, valid packet, so a discarded packet never disturbs them.
    always_comb begin
        accept   = in_valid && in_ready;
        is_coord = state inside {X1, Y1, X2, Y2};
        bad      = 1'b0;
        commit   = 1'b0;
        c_y1     = (state == Y1) ? in_data[5:0] : y1_r;
        c_y2     = (state == Y2) ? in_data[5:0] : y2_r;
        if (accept) begin
            if (state == COUNT && !(in_data == 8'd1 || in_data == 8'd2))
                bad = 1'b1;
            if (is_coord && in_data > 8'd18)
                bad = 1'b1;
`ifdef MOVE_CSUM_EN
            if (state == CSUM) begin
                if (in_data == csum_r) commit = 1'b1;
                else                   bad    = 1'b1;
            end
`else
            if (in_data <= 8'd18 && ((state == Y1 && cnt_r == 2'd1) || state == Y2))
                commit = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            move_valid <= 1'b0;
            pkt_error  <= 1'b0;
            err_count  <= '0;
            move_count <= '0;
            x_1        <= '0;
            y_1        <= '0;
            x_2        <= '0;
            y_2        <= '0;
            cnt_r      <= '0;
            x1_r       <= '0;
            y1_r       <= '0;
            x2_r       <= '0;
            y2_r       <= '0;
`ifdef MOVE_CSUM_EN
            csum_r     <= '0;
`endif
        end else begin
            in_ready  <= 1'b1;
            pkt_error <= bad;
            if (bad && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            if (accept && !bad) begin
                case (state)
                    COUNT:   cnt_r <= in_data[1:0];
                    X1:      x1_r  <= in_data[5:0];
                    Y1:      y1_r  <= in_data[5:0];
                    X2:      x2_r  <= in_data[5:0];
                    Y2:      y2_r  <= in_data[5:0];
                    default: ;
                endcase
            end
`ifdef MOVE_CSUM_EN
            if (accept)
                csum_r <= (state == IDLE) ? HDR : (csum_r ^ in_data);
`endif

            if (bad) begin
                state <= IDLE;
            end else if (commit) begin
                state      <= HOLD;
                in_ready   <= 1'b0;
                move_valid <= 1'b1;
                move_count <= cnt_r;
                x_1        <= x1_r;
                y_1        <= c_y1;
                x_2        <= (cnt_r == 2'd2) ? x2_r : 6'h3F;
                y_2        <= (cnt_r == 2'd2) ? c_y2 : 6'h3F;
            end else if (state == HOLD) begin
                if (move_valid && move_ack) begin
                    move_valid <= 1'b0;
                    state      <= IDLE;
                end else begin
                    in_ready <= 1'b0;
                end
            end else if (accept) begin
                case (state)
                    IDLE:    state <= (in_data == HDR) ? COUNT : IDLE;
                    COUNT:   state <= X1;
                    X1:      state <= Y1;
                    X2:      state <= Y2;
`ifdef MOVE_CSUM_EN
                    Y1:      state <= (cnt_r == 2'd2) ? X2 : CSUM;
                    Y2:      state <= CSUM;
`else
                    Y1:      state <= X2;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_packet_rx.sv
// Randomized self-checking bench for move_packet_rx against a packet-level reference model.
module tb_move_packet_rx;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit         ok;
        int         len;
        logic [1:0] cnt;
        logic [5:0] x1, y1, x2, y2;
    } res_t;

`ifdef MOVE_CSUM_EN
    localparam int NERR = 4;
`else
    localparam int NERR = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] x_1, y_1, x_2, y_2;
    logic [1:0] move_count;
    logic       move_valid;
    logic       move_ack;
    logic       pkt_error;
    logic [7:0] err_count;

    int   tests = 0;
    int   fails = 0;
    int   err_pulses = 0;
    int   exp_err = 0;
    res_t last;

    move_packet_rx dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .x_1(x_1), .y_1(y_1), .x_2(x_2), .y_2(y_2), .move_count(move_count),
        .move_valid(move_valid), .move_ack(move_ack), .pkt_error(pkt_error), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pkt_error === 1'b1) err_pulses++;

    // Packet-level reference: where the packet ends (or fails) and what it decodes to.
    function automatic res_t model(input bq_t b);
        res_t r;
        int i, n;
        logic [7:0] t;
`ifdef MOVE_CSUM_EN
        logic [7:0] x;
`endif
        r.ok = 0; r.len = b.size(); r.cnt = 2'd0;
        r.x1 = 6'd0; r.y1 = 6'd0; r.x2 = 6'h3F; r.y2 = 6'h3F;
        i = 0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i + 1 >= b.size()) return r;
        n = int'(b[i+1]);
        if (n != 1 && n != 2) begin r.len = i + 2; return r; end
        if (i + 2 + 2*n > b.size()) return r;
`ifdef MOVE_CSUM_EN
        x = b[i] ^ b[i+1];
`endif
        for (int j = 0; j < 2*n; j++) begin
            t = b[i+2+j];
            if (t > 8'd18) begin r.len = i + 3 + j; return r; end
`ifdef MOVE_CSUM_EN
            x = x ^ t;
`endif
        end
        r.len = i + 2 + 2*n;
`ifdef MOVE_CSUM_EN
        if (r.len >= b.size()) return r;
        r.len = r.len + 1;
        if (b[i+2+2*n] != x) return r;
`endif
        r.ok  = 1;
        r.cnt = 2'(n);
        t = b[i+2]; r.x1 = t[5:0];
        t = b[i+3]; r.y1 = t[5:0];
        if (n == 2) begin
            t = b[i+4]; r.x2 = t[5:0];
            t = b[i+5]; r.y2 = t[5:0];
        end
        return r;
    endfunction

    function automatic bq_t with_csum(input bq_t p);
`ifdef MOVE_CSUM_EN
        logic [7:0] x = 8'h00;
        foreach (p[i]) x = x ^ p[i];
        p.push_back(x);
`endif
        return p;
    endfunction

    function automatic bq_t rand_pkt();
        bq_t p;
        int n;
        logic [7:0] c;
`ifdef MOVE_CSUM_EN
        int g;
        logic [7:0] x;
`endif
        repeat ($urandom_range(0, 2)) begin
            c = 8'($urandom_range(0, 255));
            if (c == 8'hA5) c = 8'h00;
            p.push_back(c);
        end
`ifdef MOVE_CSUM_EN
        g = p.size();
`endif
        p.push_back(8'hA5);
        n = int'($urandom_range(1, 2));
        if ($urandom_range(0, 9) == 0) p.push_back(8'($urandom_range(3, 255)));
        else                           p.push_back(8'(n));
        for (int j = 0; j < 2*n; j++)
            p.push_back(($urandom_range(0, 11) == 0) ? 8'($urandom_range(19, 255)) : 8'($urandom_range(0, 18)));
`ifdef MOVE_CSUM_EN
        x = 8'h00;
        for (int j = g; j < p.size(); j++) x = x ^ p[j];
        if ($urandom_range(0, 9) == 0) x = x ^ 8'($urandom_range(1, 255));
        p.push_back(x);
`endif
        return p;
    endfunction

    function automatic bq_t err_pkt(input int k);
        bq_t p;
        case (k)
            0:       p = {8'hA5, 8'h03};
            1:       p = {8'hA5, 8'h01, 8'h13};
            2:       p = {8'hA5, 8'hA5};
            default: p = {8'hA5, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
        endcase
        return p;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
        if (t >= 20) begin
            tests++; fails++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input bq_t p);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic clear_last();
        last.ok = 0; last.len = 0; last.cnt = 2'd0;
        last.x1 = 6'd0; last.y1 = 6'd0; last.x2 = 6'd0; last.y2 = 6'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; move_ack = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        clear_last(); exp_err = 0;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests++; if (move_valid !== 1'b0 || pkt_error !== 1'b0) begin fails++; $display("FAIL reset_flags got mv=%b pe=%b want 0 0", move_valid, pkt_error); end
        tests++; if (err_count !== 8'd0 || move_count !== 2'd0) begin fails++; $display("FAIL reset_counts got ec=%0d mc=%0d want 0 0", err_count, move_count); end
        tests++; if ({x_1, y_1, x_2, y_2} !== 24'd0) begin fails++; $display("FAIL reset_coords got %h want 0", {x_1, y_1, x_2, y_2}); end
        reset = 1'b0;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_two_move();
        int pulses = err_pulses;
        send_pkt(with_csum({8'hA5, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}));
        tests++; if (move_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL two_move_hs got mv=%b ir=%b want 1 0", move_valid, in_ready); end
        tests++; if ({x_1, y_1, x_2, y_2} !== {6'd3, 6'd4, 6'd5, 6'd6}) begin fails++; $display("FAIL two_move_coords got %0d %0d %0d %0d want 3 4 5 6", x_1, y_1, x_2, y_2); end
        tests++; if (move_count !== 2'd2 || err_count !== 8'd0) begin fails++; $display("FAIL two_move_counts got mc=%0d ec=%0d want 2 0", move_count, err_count); end
        move_ack = 1'b1; @(posedge clk); #1; move_ack = 1'b0;
        tests++; if (move_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL two_move_ack got mv=%b ir=%b want 0 1", move_valid, in_ready); end
        tests++; if (err_pulses != pulses) begin fails++; $display("FAIL two_move_pulses got %0d want %0d", err_pulses, pulses); end
        last = model({8'hA5, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
    endtask

    task automatic test_one_move_late_ack();
        send_pkt(with_csum({8'hA5, 8'h01, 8'h09, 8'h09}));
        tests++; if ({x_1, y_1, x_2, y_2} !== {6'd9, 6'd9, 6'h3F, 6'h3F}) begin fails++; $display("FAIL one_move_coords got %0d %0d %h %h want 9 9 3f 3f", x_1, y_1, x_2, y_2); end
        tests++; if (move_count !== 2'd1 || move_valid !== 1'b1) begin fails++; $display("FAIL one_move_count got mc=%0d mv=%b want 1 1", move_count, move_valid); end
        in_data = 8'hA5; in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            tests++;
            if (move_valid !== 1'b1 || in_ready !== 1'b0 || {x_1, y_1, x_2, y_2} !== {6'd9, 6'd9, 6'h3F, 6'h3F}) begin
                fails++; $display("FAIL one_move_hold got mv=%b ir=%b coords=%h want 1 0 249fff", move_valid, in_ready, {x_1, y_1, x_2, y_2});
            end
        end
        in_valid = 1'b0;
        move_ack = 1'b1; @(posedge clk); #1; move_ack = 1'b0;
        tests++; if (move_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL one_move_ack got mv=%b ir=%b want 0 1", move_valid, in_ready); end
        last = model({8'hA5, 8'h01, 8'h09, 8'h09});
    endtask

    task automatic test_errors();
        int pulses = err_pulses;
        for (int k = 0; k < NERR; k++) begin
            send_pkt(err_pkt(k));
            exp_err++;
            tests++; if (pkt_error !== 1'b1 || move_valid !== 1'b0) begin fails++; $display("FAIL err%0d_flags got pe=%b mv=%b want 1 0", k, pkt_error, move_valid); end
            tests++; if (err_count !== 8'(exp_err)) begin fails++; $display("FAIL err%0d_count got %0d want %0d", k, err_count, exp_err); end
            tests++; if ({x_1, y_1, x_2, y_2, move_count} !== {last.x1, last.y1, last.x2, last.y2, last.cnt}) begin fails++; $display("FAIL err%0d_outputs_kept got %h", k, {x_1, y_1, x_2, y_2, move_count}); end
        end
        @(posedge clk); #1;
        tests++; if (pkt_error !== 1'b0) begin fails++; $display("FAIL err_pulse_width got %b want 0", pkt_error); end
        tests++; if (err_pulses - pulses != NERR) begin fails++; $display("FAIL err_pulse_count got %0d want %0d", err_pulses - pulses, NERR); end
        send_pkt(with_csum({8'hA5, 8'h02, 8'h12, 8'h00, 8'h07, 8'h11}));
        tests++; if (move_valid !== 1'b1 || {x_1, y_1, x_2, y_2} !== {6'd18, 6'd0, 6'd7, 6'd17}) begin fails++; $display("FAIL err_recover got mv=%b %0d %0d %0d %0d want 1 18 0 7 17", move_valid, x_1, y_1, x_2, y_2); end
        move_ack = 1'b1; @(posedge clk); #1; move_ack = 1'b0;
        last = model({8'hA5, 8'h02, 8'h12, 8'h00, 8'h07, 8'h11});
    endtask

    task automatic test_garbage();
        int pulses = err_pulses;
        bq_t g = {8'h00, 8'hFF, 8'h5A};
        send_pkt({g, with_csum({8'hA5, 8'h01, 8'h00, 8'h12})});
        tests++; if ({x_1, y_1, x_2, y_2} !== {6'd0, 6'd18, 6'h3F, 6'h3F} || move_valid !== 1'b1) begin fails++; $display("FAIL garbage_decode got mv=%b %0d %0d %h %h want 1 0 18 3f 3f", move_valid, x_1, y_1, x_2, y_2); end
        tests++; if (err_pulses != pulses || err_count !== 8'(exp_err)) begin fails++; $display("FAIL garbage_noerr got pulses=%0d ec=%0d want %0d %0d", err_pulses, err_count, pulses, exp_err); end
        move_ack = 1'b1; @(posedge clk); #1; move_ack = 1'b0;
        last = model({8'hA5, 8'h01, 8'h00, 8'h12});
    endtask

    task automatic test_back_to_back();
        move_ack = 1'b1;
        send_pkt(with_csum({8'hA5, 8'h01, 8'h05, 8'h06}));
        tests++; if (move_valid !== 1'b1 || {x_1, y_1} !== {6'd5, 6'd6}) begin fails++; $display("FAIL b2b_first got mv=%b %0d %0d want 1 5 6", move_valid, x_1, y_1); end
        @(posedge clk); #1;
        tests++; if (move_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_hold_one got mv=%b ir=%b want 0 1", move_valid, in_ready); end
        send_pkt(with_csum({8'hA5, 8'h02, 8'h0B, 8'h0C, 8'h0D, 8'h0E}));
        tests++; if (move_valid !== 1'b1 || {x_1, y_1, x_2, y_2} !== {6'd11, 6'd12, 6'd13, 6'd14}) begin fails++; $display("FAIL b2b_second got mv=%b %0d %0d %0d %0d want 1 11 12 13 14", move_valid, x_1, y_1, x_2, y_2); end
        @(posedge clk); #1; move_ack = 1'b0;
        tests++; if (move_valid !== 1'b0) begin fails++; $display("FAIL b2b_second_ack got mv=%b want 0", move_valid); end
        last = model({8'hA5, 8'h02, 8'h0B, 8'h0C, 8'h0D, 8'h0E});
    endtask

    task automatic test_reset_mid();
        int pulses;
        send_pkt({8'hA5, 8'h02, 8'h03});
        reset = 1'b1; @(posedge clk); #1;
        clear_last(); exp_err = 0; pulses = err_pulses;
        tests++; if (move_valid !== 1'b0 || in_ready !== 1'b0 || err_count !== 8'd0 || move_count !== 2'd0) begin fails++; $display("FAIL rstmid_flags got mv=%b ir=%b ec=%0d mc=%0d want 0 0 0 0", move_valid, in_ready, err_count, move_count); end
        tests++; if ({x_1, y_1, x_2, y_2} !== 24'd0) begin fails++; $display("FAIL rstmid_coords got %h want 0", {x_1, y_1, x_2, y_2}); end
        reset = 1'b0; @(posedge clk); #1;
        send_pkt(with_csum({8'hA5, 8'h02, 8'h01, 8'h02, 8'h11, 8'h12}));
        tests++; if (move_valid !== 1'b1 || {x_1, y_1, x_2, y_2, move_count} !== {6'd1, 6'd2, 6'd17, 6'd18, 2'd2}) begin fails++; $display("FAIL rstmid_decode got mv=%b %0d %0d %0d %0d mc=%0d", move_valid, x_1, y_1, x_2, y_2, move_count); end
        tests++; if (err_pulses != pulses) begin fails++; $display("FAIL rstmid_noerr got %0d want %0d", err_pulses, pulses); end
        move_ack = 1'b1; @(posedge clk); #1; move_ack = 1'b0;
        last = model({8'hA5, 8'h02, 8'h01, 8'h02, 8'h11, 8'h12});
    endtask

    task automatic test_random();
        bq_t  p;
        res_t r;
        int   d;
        for (int k = 0; k < 60; k++) begin
            p = rand_pkt();
            r = model(p);
            while (p.size() > r.len) void'(p.pop_back());
            send_pkt(p);
            if (r.ok) begin
                tests++; if (move_valid !== 1'b1 || {x_1, y_1, x_2, y_2, move_count} !== {r.x1, r.y1, r.x2, r.y2, r.cnt}) begin fails++; $display("FAIL rand%0d_decode got mv=%b %h want 1 %h", k, move_valid, {x_1, y_1, x_2, y_2, move_count}, {r.x1, r.y1, r.x2, r.y2, r.cnt}); end
                d = int'($urandom_range(0, 3));
                repeat (d) begin
                    @(posedge clk); #1;
                    tests++; if (move_valid !== 1'b1 || in_ready !== 1'b0 || {x_1, y_1, x_2, y_2} !== {r.x1, r.y1, r.x2, r.y2}) begin fails++; $display("FAIL rand%0d_hold got mv=%b ir=%b want 1 0", k, move_valid, in_ready); end
                end
                move_ack = 1'b1; @(posedge clk); #1; move_ack = 1'b0;
                tests++; if (move_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rand%0d_ack got mv=%b ir=%b want 0 1", k, move_valid, in_ready); end
                last = r;
            end else begin
                exp_err = (exp_err < 255) ? exp_err + 1 : 255;
                tests++; if (pkt_error !== 1'b1 || move_valid !== 1'b0) begin fails++; $display("FAIL rand%0d_err got pe=%b mv=%b want 1 0", k, pkt_error, move_valid); end
                tests++; if (err_count !== 8'(exp_err) || {x_1, y_1, x_2, y_2, move_count} !== {last.x1, last.y1, last.x2, last.y2, last.cnt}) begin fails++; $display("FAIL rand%0d_errstate got ec=%0d want %0d", k, err_count, exp_err); end
            end
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 300; k++) begin
            send_pkt({8'hA5, 8'h03});
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        tests++; if (err_count !== 8'(exp_err)) begin fails++; $display("FAIL sat_model got %0d want %0d", err_count, exp_err); end
        tests++; if (err_count !== 8'hFF) begin fails++; $display("FAIL sat_255 got %0d want 255", err_count); end
    endtask

    initial begin
        in_data = 8'h00; in_valid = 1'b0; move_ack = 1'b0; reset = 1'b1;
        test_reset();
        test_two_move();
        test_one_move_late_ack();
        test_errors();
        test_garbage();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
